// File: rtl/mvu_weight_addr_seq_if.sv
// Handshake and address bundle between the MVAU weight-address sequencer,
// the input activation buffer and the PE/SIMD datapath.
interface mvu_weight_addr_seq_if #(
  parameter int WMEM_ADDR_BW = 2,
  parameter int IB_ADDR_BW   = 1
);
  logic                    in_valid;
  logic                    in_release;
  logic                    o_ready;
  logic [WMEM_ADDR_BW-1:0] wmem_addr;
  logic [IB_ADDR_BW-1:0]   ib_addr;
  logic                    issue;
  logic                    dp_valid;
  logic                    dp_first;
  logic                    dp_last;
  logic                    busy;

  modport master (
    input  in_valid,
    input  o_ready,
    output in_release,
    output wmem_addr,
    output ib_addr,
    output issue,
    output dp_valid,
    output dp_first,
    output dp_last,
    output busy
  );

  modport slave (
    output in_valid,
    output o_ready,
    input  in_release,
    input  wmem_addr,
    input  ib_addr,
    input  issue,
    input  dp_valid,
    input  dp_first,
    input  dp_last,
    input  busy
  );
endinterface

// File: rtl/mvu_weight_addr_seq.sv
// Walks all NF*SF weight words for one input vector (sf inner, nf outer) and
// produces accumulator control flags aligned to the 1-cycle weight-memory read.
module mvu_weight_addr_seq #(
  parameter int MATRIXW = 4,
  parameter int MATRIXH = 4,
  parameter int SIMD    = 2,
  parameter int PE      = 2
) (
  input  logic                 clock,
  input  logic                 rst_n,
  mvu_weight_addr_seq_if.master bus
);

  localparam int SF           = MATRIXW / SIMD;
  localparam int NF           = MATRIXH / PE;
  localparam int WMEM_DEPTH   = SF * NF;
  localparam int WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
  localparam int IB_ADDR_BW   = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_BW        = (NF > 1) ? $clog2(NF) : 1;

  localparam logic [IB_ADDR_BW-1:0]   SF_LAST   = IB_ADDR_BW'(SF - 1);
  localparam logic [NF_BW-1:0]        NF_LAST   = NF_BW'(NF - 1);
  localparam logic [IB_ADDR_BW-1:0]   SF_ONE    = IB_ADDR_BW'(1);
  localparam logic [NF_BW-1:0]        NF_ONE    = NF_BW'(1);
  localparam logic [WMEM_ADDR_BW-1:0] WMEM_ONE  = WMEM_ADDR_BW'(1);

  if ((MATRIXW % SIMD) != 0) begin : g_bad_matrixw
    $error("mvu_weight_addr_seq: MATRIXW must be a multiple of SIMD");
  end
  if ((MATRIXH % PE) != 0) begin : g_bad_matrixh
    $error("mvu_weight_addr_seq: MATRIXH must be a multiple of PE");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IB_ADDR_BW-1:0]   sf_cnt_q, sf_cnt_d;
  logic [NF_BW-1:0]        nf_cnt_q, nf_cnt_d;
  logic [WMEM_ADDR_BW-1:0] wmem_addr_q, wmem_addr_d;
  logic                    issue_q, issue_d;
  logic                    dp_valid_q, dp_valid_d;
  logic                    dp_first_q, dp_first_d;
  logic                    dp_last_q, dp_last_d;

  logic sf_last;
  logic word_last;

  assign sf_last   = (sf_cnt_q == SF_LAST);
  assign word_last = sf_last && (nf_cnt_q == NF_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sf_cnt_q    <= '0;
      nf_cnt_q    <= '0;
      wmem_addr_q <= '0;
      issue_q     <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_first_q  <= 1'b0;
      dp_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sf_cnt_q    <= sf_cnt_d;
      nf_cnt_q    <= nf_cnt_d;
      wmem_addr_q <= wmem_addr_d;
      issue_q     <= issue_d;
      dp_valid_q  <= dp_valid_d;
      dp_first_q  <= dp_first_d;
      dp_last_q   <= dp_last_d;
    end
  end

  // A stalled RUN cycle holds everything so the memories keep re-reading the same word.
  always_comb begin
    state_d     = state_q;
    sf_cnt_d    = sf_cnt_q;
    nf_cnt_d    = nf_cnt_q;
    wmem_addr_d = wmem_addr_q;
    issue_d     = issue_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d     = RUN;
          sf_cnt_d    = '0;
          nf_cnt_d    = '0;
          wmem_addr_d = '0;
          issue_d     = 1'b1;
        end
      end
      RUN: begin
        if (bus.o_ready) begin
          if (word_last) begin
            state_d     = IDLE;
            sf_cnt_d    = '0;
            nf_cnt_d    = '0;
            wmem_addr_d = '0;
            issue_d     = 1'b0;
          end else if (sf_last) begin
            sf_cnt_d    = '0;
            nf_cnt_d    = nf_cnt_q + NF_ONE;
            wmem_addr_d = wmem_addr_q + WMEM_ONE;
          end else begin
            sf_cnt_d    = sf_cnt_q + SF_ONE;
            wmem_addr_d = wmem_addr_q + WMEM_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        issue_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_first_d = dp_first_q;
    dp_last_d  = dp_last_q;
    if (bus.o_ready) begin
      dp_valid_d = issue_q;
      dp_first_d = issue_q && (sf_cnt_q == '0);
      dp_last_d  = issue_q && sf_last;
    end
  end

  assign bus.in_release = issue_q && word_last && bus.o_ready;
  assign bus.wmem_addr  = wmem_addr_q;
  assign bus.ib_addr    = sf_cnt_q;
  assign bus.issue      = issue_q;
  assign bus.dp_valid   = dp_valid_q;
  assign bus.dp_first   = dp_first_q;
  assign bus.dp_last    = dp_last_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mvu_weight_addr_seq.sv
// Bench for mvu_weight_addr_seq: a 2x2-fold instance and an SF=NF=1 instance run
// in lockstep against a word-index reference model, with directed and random traffic.
module tb_mvu_weight_addr_seq;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic o_ready = 1'b0;

  int checkCount = 0;
  int passCount = 0;

  bit m_busy [2];
  int m_k    [2];
  bit m_dpv  [2];
  bit m_dpf  [2];
  bit m_dpl  [2];

  always #5 clock = ~clock;

  mvu_weight_addr_seq_if #(.WMEM_ADDR_BW(2), .IB_ADDR_BW(1)) bus_a ();
  mvu_weight_addr_seq_if #(.WMEM_ADDR_BW(1), .IB_ADDR_BW(1)) bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.o_ready  = o_ready;
  assign bus_b.in_valid = in_valid;
  assign bus_b.o_ready  = o_ready;

  mvu_weight_addr_seq #(.MATRIXW(4), .MATRIXH(4), .SIMD(2), .PE(2)) dut_a (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  mvu_weight_addr_seq #(.MATRIXW(2), .MATRIXH(2), .SIMD(2), .PE(2)) dut_b (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  function automatic int sfOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int nfOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_k[d]    = 0;
      m_dpv[d]  = 1'b0;
      m_dpf[d]  = 1'b0;
      m_dpl[d]  = 1'b0;
    end
  endtask

  // One clock edge of the reference: k is the linear word index within the pass.
  task automatic modelStep(input bit iv, input bit rdy);
    for (int d = 0; d < 2; d++) begin
      int total;
      total = sfOf(d) * nfOf(d);
      if (rdy) begin
        m_dpv[d] = m_busy[d];
        m_dpf[d] = m_busy[d] && ((m_k[d] % sfOf(d)) == 0);
        m_dpl[d] = m_busy[d] && ((m_k[d] % sfOf(d)) == sfOf(d) - 1);
      end
      if (!m_busy[d]) begin
        if (iv) begin
          m_busy[d] = 1'b1;
          m_k[d]    = 0;
        end
      end else if (rdy) begin
        if (m_k[d] == total - 1) begin
          m_busy[d] = 1'b0;
          m_k[d]    = 0;
        end else begin
          m_k[d] = m_k[d] + 1;
        end
      end
    end
  endtask

  task automatic checkDut(input int d, input logic iss, input int wmem, input int ib,
                          input logic rel, input logic dv, input logic df, input logic dl,
                          input logic bsy);
    int total;
    total = sfOf(d) * nfOf(d);
    checkOutput($sformatf("d%0d issue", d), int'(iss), int'(m_busy[d]));
    checkOutput($sformatf("d%0d wmem_addr", d), wmem, m_busy[d] ? m_k[d] : 0);
    checkOutput($sformatf("d%0d ib_addr", d), ib, m_busy[d] ? (m_k[d] % sfOf(d)) : 0);
    checkOutput($sformatf("d%0d in_release", d), int'(rel),
                int'(m_busy[d] && (m_k[d] == total - 1) && o_ready));
    checkOutput($sformatf("d%0d dp_valid", d), int'(dv), int'(m_dpv[d]));
    checkOutput($sformatf("d%0d dp_first", d), int'(df), int'(m_dpf[d]));
    checkOutput($sformatf("d%0d dp_last", d), int'(dl), int'(m_dpl[d]));
    checkOutput($sformatf("d%0d busy", d), int'(bsy), int'(m_busy[d]));
  endtask

  task automatic checkAll();
    checkDut(0, bus_a.issue, int'(bus_a.wmem_addr), int'(bus_a.ib_addr), bus_a.in_release,
             bus_a.dp_valid, bus_a.dp_first, bus_a.dp_last, bus_a.busy);
    checkDut(1, bus_b.issue, int'(bus_b.wmem_addr), int'(bus_b.ib_addr), bus_b.in_release,
             bus_b.dp_valid, bus_b.dp_first, bus_b.dp_last, bus_b.busy);
  endtask

  // Inputs change on the falling edge, outputs are checked 1 ns later, model follows the rising edge.
  task automatic applyStimulus(input bit iv, input bit rdy);
    @(negedge clock);
    in_valid = iv;
    o_ready  = rdy;
    #1;
    checkAll();
    @(posedge clock);
    modelStep(iv, rdy);
  endtask

  initial begin
    int releases;
    bit reached;

    modelReset();
    #1;
    checkAll();
    @(posedge clock);
    #1 rst_n = 1'b1;

    releases = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (bus_a.in_release) releases++;
    end
    checkOutput("d0 releases_in_10", releases, 2);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);

    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);

    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      applyStimulus(1'b1, 1'b1);
      reached = m_busy[0] && (m_k[0] == 2);
    end
    checkOutput("reach_addr2", int'(reached), 1);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      if (i == 211) begin
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
